// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU control path.
package cpu_pkg;

  localparam int CPU_DATA_WIDTH    = 16;
  localparam int CPU_OPCODE_WIDTH  = 5;
  localparam int CPU_OPERAND_WIDTH = 11;

  typedef enum logic [CPU_OPCODE_WIDTH-1:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111,
    OP_BEQ  = 5'b01000,
    OP_BNE  = 5'b01001,
    OP_JMP  = 5'b01010
  } opcode_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_HALT
  } state_t;

  // Accumulator source select; 2'b11 is never produced.
  localparam logic [1:0] SEL_MEM = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_IMM = 2'b10;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // Strobes asserted during the single EXECUTE cycle of an instruction.
  typedef struct packed {
    logic [1:0] sel;
    logic       alu_sel_b;
    logic       alu_op;
    logic       acc_wr;
    logic       mem_wr;
    logic       pc_inc;
    logic       pc_load;
    logic       halt;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '0;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode into the EXECUTE-cycle strobe bundle.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [CPU_OPCODE_WIDTH-1:0] opcode_i,
  input  logic                        zero_i,
  output strobes_t                    strobes_o
);

  // Map each opcode to its strobes; unknown opcodes behave as NOP.
  always_comb begin
    strobes_o = STROBES_IDLE;
    case (opcode_i)
      OP_HLT: strobes_o.halt = 1'b1;
      OP_STO: begin
        strobes_o.mem_wr = 1'b1;
        strobes_o.pc_inc = 1'b1;
      end
      OP_LD: begin
        strobes_o.sel    = SEL_MEM;
        strobes_o.acc_wr = 1'b1;
        strobes_o.pc_inc = 1'b1;
      end
      OP_LDI: begin
        strobes_o.sel    = SEL_IMM;
        strobes_o.acc_wr = 1'b1;
        strobes_o.pc_inc = 1'b1;
      end
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
        strobes_o.sel       = SEL_ALU;
        strobes_o.alu_sel_b = opcode_i[0];
        strobes_o.alu_op    = opcode_i[1] ? ALU_SUB : ALU_ADD;
        strobes_o.acc_wr    = 1'b1;
        strobes_o.pc_inc    = 1'b1;
      end
      OP_BEQ: begin
        strobes_o.pc_load = zero_i;
        strobes_o.pc_inc  = ~zero_i;
      end
      OP_BNE: begin
        strobes_o.pc_load = ~zero_i;
        strobes_o.pc_inc  = zero_i;
      end
      OP_JMP: strobes_o.pc_load = 1'b1;
      default: strobes_o.pc_inc = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE control FSM: holds the instruction
// register and gates the decoded strobes into the datapath.
module control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH    = CPU_DATA_WIDTH,
  parameter int OPCODE_WIDTH  = CPU_OPCODE_WIDTH,
  parameter int OPERAND_WIDTH = CPU_OPERAND_WIDTH
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [DATA_WIDTH-1:0]    instr_in,
  input  logic                     zero_in,
  output logic [OPERAND_WIDTH-1:0] operand_out,
  output logic [1:0]               sel_3x1_out,
  output logic                     alu_sel_b_out,
  output logic                     alu_op_out,
  output logic                     addr_sel_out,
  output logic                     acc_wr_out,
  output logic                     mem_wr_out,
  output logic                     pc_inc_out,
  output logic                     pc_load_out,
  output logic                     halted_out
);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  strobes_t              dec;

  instr_decoder u_decoder (
    .opcode_i  (ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH]),
    .zero_i    (zero_in),
    .strobes_o (dec)
  );

  assign operand_out = ir_q[OPERAND_WIDTH-1:0];

  // State and instruction registers; reset clears both immediately.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= ST_INIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Sequence INIT -> FETCH -> DECODE -> EXECUTE, parking in HALT on HLT.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_INIT:    state_d = ST_FETCH;
      ST_FETCH: begin
        ir_d    = instr_in;
        state_d = ST_DECODE;
      end
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = dec.halt ? ST_HALT : ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_INIT;
    endcase
  end

  // Strobes come only from the registered state and IR, so a reset drops them at once.
  always_comb begin
    sel_3x1_out   = SEL_MEM;
    alu_sel_b_out = 1'b0;
    alu_op_out    = ALU_ADD;
    addr_sel_out  = 1'b0;
    acc_wr_out    = 1'b0;
    mem_wr_out    = 1'b0;
    pc_inc_out    = 1'b0;
    pc_load_out   = 1'b0;
    halted_out    = 1'b0;
    case (state_q)
      ST_DECODE: addr_sel_out = 1'b1;
      ST_EXECUTE: begin
        addr_sel_out  = 1'b1;
        sel_3x1_out   = dec.sel;
        alu_sel_b_out = dec.alu_sel_b;
        alu_op_out    = dec.alu_op;
        acc_wr_out    = dec.acc_wr;
        mem_wr_out    = dec.mem_wr;
        pc_inc_out    = dec.pc_inc;
        pc_load_out   = dec.pc_load;
      end
      ST_HALT: halted_out = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: table-driven instruction vectors checked
// through a scoreboard queue, plus HALT and mid-instruction reset sequences.
module tb_control_unit;
  import cpu_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [15:0] instr_in;
  logic        zero_in;
  logic [10:0] operand_out;
  logic [1:0]  sel_3x1_out;
  logic        alu_sel_b_out, alu_op_out, addr_sel_out, acc_wr_out;
  logic        mem_wr_out, pc_inc_out, pc_load_out, halted_out;

  control_unit dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .instr_in      (instr_in),
    .zero_in       (zero_in),
    .operand_out   (operand_out),
    .sel_3x1_out   (sel_3x1_out),
    .alu_sel_b_out (alu_sel_b_out),
    .alu_op_out    (alu_op_out),
    .addr_sel_out  (addr_sel_out),
    .acc_wr_out    (acc_wr_out),
    .mem_wr_out    (mem_wr_out),
    .pc_inc_out    (pc_inc_out),
    .pc_load_out   (pc_load_out),
    .halted_out    (halted_out)
  );

  always #5 clk_in = ~clk_in;

  // Output word: [9:8] sel, 7 alu_sel_b, 6 alu_op, 5 addr_sel, 4 acc_wr,
  // 3 mem_wr, 2 pc_inc, 1 pc_load, 0 halted.
  localparam logic [15:0] O_IDLE   = 16'h0000;
  localparam logic [15:0] O_DECODE = 16'h0020;
  localparam logic [15:0] O_HALTED = 16'h0001;

  typedef struct {
    logic [15:0] instr;
    logic        zero;
    logic [15:0] exp;
  } vec_t;

  typedef struct packed {
    logic [15:0] strb;
    logic [10:0] opd;
  } sb_t;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t tbl[14];
  sb_t  sb_q[$];

  function automatic logic [15:0] outs();
    return {6'b0, sel_3x1_out, alu_sel_b_out, alu_op_out, addr_sel_out,
            acc_wr_out, mem_wr_out, pc_inc_out, pc_load_out, halted_out};
  endfunction

  // Expected EXECUTE word (addr_sel is always 1 there, halted 0).
  function automatic logic [15:0] mk(input logic [1:0] sel, input logic b, input logic op,
                                     input logic acc, input logic mem, input logic inc,
                                     input logic ld);
    return {6'b0, sel, b, op, 1'b1, acc, mem, inc, ld, 1'b0};
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Runs one instruction starting in a FETCH cycle; returns in the next cycle after EXECUTE.
  task automatic run_instr(input logic [15:0] ins, input logic z, input logic [15:0] exp);
    sb_t e;
    instr_in = ins;
    zero_in  = ~z;
    sb_q.push_back('{strb: exp, opd: ins[10:0]});
    check("fetch_strobes", outs(), O_IDLE);
    step();
    instr_in = 16'($urandom);
    zero_in  = z;
    check("decode_strobes", outs(), O_DECODE);
    check("decode_operand", {5'b0, operand_out}, {5'b0, ins[10:0]});
    step();
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 16'h0001, 16'h0000);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("exec_%h_z%0d", ins, z), outs(), e.strb);
      check("exec_operand", {5'b0, operand_out}, {5'b0, e.opd});
    end
    step();
  endtask

  // Invariants that must hold on every cycle.
  always @(negedge clk_in) begin
    n_cmp++;
    if ((pc_inc_out && pc_load_out) || (acc_wr_out && mem_wr_out) || (sel_3x1_out == 2'b11)) begin
      n_err++;
      $display("FAIL invariant: inc=%0d load=%0d acc=%0d mem=%0d sel=%b required exclusive and sel!=11",
               pc_inc_out, pc_load_out, acc_wr_out, mem_wr_out, sel_3x1_out);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{16'h1805, 1'b0, mk(SEL_IMM, 0, 0, 1, 0, 1, 0)};  // LDI 5
    tbl[1]  = '{16'h2010, 1'b0, mk(SEL_ALU, 0, 0, 1, 0, 1, 0)};  // ADD 0x010
    tbl[2]  = '{16'h3803, 1'b1, mk(SEL_ALU, 1, 1, 1, 0, 1, 0)};  // SUBI 3
    tbl[3]  = '{16'h0FFF, 1'b0, mk(SEL_MEM, 0, 0, 0, 1, 1, 0)};  // STO 0x7FF
    tbl[4]  = '{16'h1123, 1'b1, mk(SEL_MEM, 0, 0, 1, 0, 1, 0)};  // LD 0x123
    tbl[5]  = '{16'h2805, 1'b0, mk(SEL_ALU, 1, 0, 1, 0, 1, 0)};  // ADDI 5
    tbl[6]  = '{16'h3004, 1'b0, mk(SEL_ALU, 0, 1, 1, 0, 1, 0)};  // SUB 0x004
    tbl[7]  = '{16'h4020, 1'b1, mk(SEL_MEM, 0, 0, 0, 0, 0, 1)};  // BEQ taken
    tbl[8]  = '{16'h4020, 1'b0, mk(SEL_MEM, 0, 0, 0, 0, 1, 0)};  // BEQ not taken
    tbl[9]  = '{16'h4820, 1'b1, mk(SEL_MEM, 0, 0, 0, 0, 1, 0)};  // BNE not taken
    tbl[10] = '{16'h4820, 1'b0, mk(SEL_MEM, 0, 0, 0, 0, 0, 1)};  // BNE taken
    tbl[11] = '{16'h53AB, 1'b0, mk(SEL_MEM, 0, 0, 0, 0, 0, 1)};  // JMP 0x3AB
    tbl[12] = '{16'hF801, 1'b1, mk(SEL_MEM, 0, 0, 0, 0, 1, 0)};  // undefined opcode -> NOP
    tbl[13] = '{16'h5800, 1'b0, mk(SEL_MEM, 0, 0, 0, 0, 1, 0)};  // first unused opcode -> NOP

    // Reset state
    reset_in = 1'b1;
    instr_in = 16'h0000;
    zero_in  = 1'b0;
    #2;
    check("reset_outputs", outs(), O_IDLE);
    check("reset_operand", {5'b0, operand_out}, 16'h0000);
    step();
    step();
    reset_in = 1'b0;
    check("init_outputs", outs(), O_IDLE);
    step();

    // Table-driven instructions, back to back
    for (int i = 0; i < 14; i++) run_instr(tbl[i].instr, tbl[i].zero, tbl[i].exp);

    // HLT parks the FSM
    run_instr(16'h0000, 1'b0, O_DECODE);
    for (int i = 0; i < 20; i++) begin
      instr_in = 16'($urandom);
      zero_in  = 1'($urandom);
      check($sformatf("halt_cycle_%0d", i), outs(), O_HALTED);
      step();
    end
    reset_in = 1'b1;
    #1;
    check("halt_reset_outputs", outs(), O_IDLE);
    check("halt_reset_operand", {5'b0, operand_out}, 16'h0000);
    step();
    reset_in = 1'b0;
    check("halt_exit_init", outs(), O_IDLE);
    step();
    run_instr(16'h1805, 1'b0, mk(SEL_IMM, 0, 0, 1, 0, 1, 0));

    // Reset asserted in the middle of STO's EXECUTE cycle
    instr_in = 16'h0FFF;
    step();
    step();
    check("sto_exec_before_reset", outs(), mk(SEL_MEM, 0, 0, 0, 1, 1, 0));
    #2;
    reset_in = 1'b1;
    #1;
    check("sto_mem_wr_async_drop", {15'b0, mem_wr_out}, 16'h0000);
    check("sto_reset_outputs", outs(), O_IDLE);
    step();
    reset_in = 1'b0;
    check("restart_init", outs(), O_IDLE);
    step();
    run_instr(16'h2010, 1'b0, mk(SEL_ALU, 0, 0, 1, 0, 1, 0));

    if (sb_q.size() != 0) check("scoreboard_leftover", 16'(sb_q.size()), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
